// File: rtl/joy_db15_pkg.sv
// Shared types and constants for the DB15 joystick responder.
package joy_db15_pkg;

  localparam int unsigned BTN_BITS_DEF   = 12;
  localparam int unsigned FRAME_BITS_DEF = 24;
  localparam int unsigned SYNC_LAT       = 3;
  localparam int unsigned SYNC_LAT_FILT  = 5;

  typedef enum logic {
    ST_LOAD,
    ST_SHIFT
  } db15_tx_state_t;

  typedef logic [11:0] db15_btn_t;

endpackage

// File: rtl/joy_db15_sync.sv
// Async input synchronizer with rise/fall pulses.
// JOY_DB15_TX_GLITCH_FILTER_EN adds a 3-sample majority filter (+2 clk latency).
module joy_db15_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q, lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
    end
  end

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
  logic h1_q, h2_q, filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q   <= RST_VAL;
      h2_q   <= RST_VAL;
      filt_q <= RST_VAL;
    end else begin
      h1_q   <= s2_q;
      h2_q   <= h1_q;
      filt_q <= (s2_q & h1_q) | (s2_q & h2_q) | (h1_q & h2_q);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= RST_VAL;
    else        prev_q <= lvl;
  end

  assign level_o = lvl;
  assign rise_o  = lvl & ~prev_q;
  assign fall_o  = ~lvl & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick responder: 74HC165-style load/shift chain with link status.
// Optional macro JOY_DB15_TX_GLITCH_FILTER_EN enables input majority filtering.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int unsigned BTN_BITS    = BTN_BITS_DEF,
  parameter int unsigned TIMEOUT_CYC = 2400000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        joy_clk,
  input  logic        joy_load,
  output logic        joy_data,
  output logic        frame_done,
  output logic        overrun,
  output logic        link_active
);

  localparam int unsigned FRAME = 2 * BTN_BITS;
  localparam int unsigned CNT_W = $clog2(FRAME + 1);
  localparam logic [21:0] TO_MAX = 22'(TIMEOUT_CYC);

  logic ld_lvl, ld_rise, ck_rise;
  logic ld_fall_unused, ck_lvl_unused, ck_fall_unused, unused_hi;

  assign unused_hi = ^{joystick1[15:BTN_BITS], joystick2[15:BTN_BITS]};

  // Load sync idles high so reset release never looks like a load edge.
  joy_db15_sync #(.RST_VAL(1'b1)) u_sync_load (
    .clk    (clk),
    .rst_n  (reset_n),
    .async_i(joy_load),
    .level_o(ld_lvl),
    .rise_o (ld_rise),
    .fall_o (ld_fall_unused)
  );

  joy_db15_sync #(.RST_VAL(1'b0)) u_sync_clk (
    .clk    (clk),
    .rst_n  (reset_n),
    .async_i(joy_clk),
    .level_o(ck_lvl_unused),
    .rise_o (ck_rise),
    .fall_o (ck_fall_unused)
  );

  db15_tx_state_t   state_q, state_d;
  logic [FRAME-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [21:0]      to_q, to_d;
  logic             data_q, data_d, fd_q, fd_d, ovr_q, ovr_d, la_q, la_d;
  logic [FRAME-1:0] load_val;

  assign load_val = ~{joystick2[BTN_BITS-1:0], joystick1[BTN_BITS-1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_LOAD;
      sr_q    <= '1;
      cnt_q   <= '0;
      to_q    <= '0;
      data_q  <= 1'b1;
      fd_q    <= 1'b0;
      ovr_q   <= 1'b0;
      la_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      data_q  <= data_d;
      fd_q    <= fd_d;
      ovr_q   <= ovr_d;
      la_q    <= la_d;
    end
  end

  // State is entered LOAD after reset but only loads while joy_load is low,
  // so nothing shifts until the reader issues a full load pulse.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    fd_d    = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (!ld_lvl) begin
          sr_d  = load_val;
          cnt_d = '0;
          ovr_d = 1'b0;
        end
        if (ld_rise) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!ld_lvl) begin
          state_d = ST_LOAD;
          sr_d    = load_val;
          cnt_d   = '0;
          ovr_d   = 1'b0;
        end else if (ck_rise) begin
          sr_d = {1'b1, sr_q[FRAME-1:1]};
          if (cnt_q == CNT_W'(FRAME)) begin
            ovr_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            fd_d  = (cnt_q == CNT_W'(FRAME - 1));
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // During load the wire follows joystick1[0] directly for 1-clk latency.
  always_comb begin
    data_d = ld_lvl ? sr_q[0] : ~joystick1[0];
  end

  always_comb begin
    to_d = to_q;
    la_d = la_q;
    if (ld_rise) begin
      to_d = '0;
      la_d = 1'b1;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + 22'd1;
      if (to_q == TO_MAX - 22'd1) la_d = 1'b0;
    end
  end

  assign joy_data    = data_q;
  assign frame_done  = fd_q;
  assign overrun     = ovr_q;
  assign link_active = la_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Randomized reader-side bench for joy_db15_tx against a bit-order model.
module tb_joy_db15_tx;
  import joy_db15_pkg::*;

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
  localparam int unsigned PW  = 6;
  localparam int unsigned LAT = SYNC_LAT_FILT;
`else
  localparam int unsigned PW  = 4;
  localparam int unsigned LAT = SYNC_LAT;
`endif
  localparam int unsigned TO = 1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        joy_clk = 1'b0;
  logic        joy_load = 1'b1;
  logic [15:0] joystick1 = '0;
  logic [15:0] joystick2 = '0;
  logic        joy_data, frame_done, overrun, link_active;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;

  joy_db15_tx #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .overrun    (overrun),
    .link_active(link_active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reader sees player 1 buttons 0..11, then player 2 0..11, low = pressed, then idle 1s.
  function automatic logic exp_bit(input logic [15:0] a, input logic [15:0] b, input int unsigned k);
    if (k < 12) return ~a[k];
    else if (k < 24) return ~b[k-12];
    else return 1'b1;
  endfunction

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clk();
    joy_clk = 1'b1;
    wait_clk(PW);
    joy_clk = 1'b0;
    wait_clk(PW);
  endtask

  task automatic run_frame(input logic [15:0] j1, input logic [15:0] j2, input int unsigned nclk,
                           input bit clk_in_load, input bit glitch);
    int base;
    joystick1 = j1;
    joystick2 = j2;
    joy_load  = 1'b0;
    if (clk_in_load) begin
      pulse_clk();
      pulse_clk();
    end else begin
      wait_clk(2 * PW);
    end
    check("ld_ovr", overrun, 0);
    check("ld_data", joy_data, exp_bit(j1, j2, 0));
    joy_load = 1'b1;
    wait_clk(PW);
    check("link_up", link_active, 1);
    base = fd_cnt;
    joystick1 = 16'($urandom);
    joystick2 = 16'($urandom);
    for (int unsigned k = 0; k < nclk; k++) begin
      if (glitch) begin
        joy_clk = 1'b1;
        wait_clk(1);
        joy_clk  = 1'b0;
        joy_load = 1'b0;
        wait_clk(1);
        joy_load = 1'b1;
        wait_clk(PW);
      end
      check($sformatf("bit%0d", k), joy_data, exp_bit(j1, j2, k));
      pulse_clk();
      check($sformatf("fd%0d", k), fd_cnt - base, (k + 1 >= 24) ? 1 : 0);
      check($sformatf("ovr%0d", k), overrun, (k + 1 > 24) ? 1 : 0);
    end
    check("end_data", joy_data, exp_bit(j1, j2, nclk));
  endtask

  initial begin
    int base;

    for (int i = 0; i < 6; i++) begin
      joy_load = ~joy_load;
      wait_clk(2);
    end
    joy_load = 1'b1;
    check("rst_data", joy_data, 1);
    check("rst_link", link_active, 0);
    check("rst_ovr", overrun, 0);
    check("rst_fd", frame_done, 0);
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(2);
    base = fd_cnt;
    repeat (3) pulse_clk();
    check("post_rst_data", joy_data, 1);
    check("post_rst_fd", fd_cnt - base, 0);
    check("post_rst_ovr", overrun, 0);
    check("post_rst_link", link_active, 0);

    run_frame(16'h0015, 16'h0A00, 24, 1'b0, 1'b0);
    run_frame(16'h0015, 16'h0A00, 26, 1'b0, 1'b0);
    run_frame(16'($urandom), 16'($urandom), 24, 1'b0, 1'b0);

    joystick1 = '0;
    joy_load  = 1'b0;
    wait_clk(2 * PW);
    check("transp0", joy_data, 1);
    joystick1 = 16'h0001;
    wait_clk(1);
    check("transp1", joy_data, 0);
    run_frame(16'($urandom), 16'($urandom), 24, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++)
      run_frame(16'($urandom), 16'($urandom), $urandom_range(20, 28), 1'b0, 1'b0);

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
    run_frame(16'($urandom), 16'($urandom), 25, 1'b0, 1'b1);
`endif

    joystick1 = 16'h0FFF;
    joystick2 = '0;
    joy_load  = 1'b0;
    wait_clk(2 * PW);
    joy_load = 1'b1;
    wait_clk(PW);
    repeat (5) pulse_clk();
    check("pre_mrst_data", joy_data, exp_bit(16'h0FFF, 16'h0000, 5));
    #2 reset_n = 1'b0;
    #1;
    check("mrst_data", joy_data, 1);
    check("mrst_link", link_active, 0);
    check("mrst_ovr", overrun, 0);
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(2);
    base = fd_cnt;
    repeat (3) pulse_clk();
    check("mrst_post_data", joy_data, 1);
    check("mrst_post_fd", fd_cnt - base, 0);
    check("mrst_post_link", link_active, 0);
    run_frame(16'($urandom), 16'($urandom), 24, 1'b0, 1'b0);

    wait_clk(TO + 100);
    check("to_idle", link_active, 0);
    joy_load = 1'b0;
    wait_clk(2 * PW);
    joy_load = 1'b1;
    wait_clk(LAT - 1);
    check("to_pre", link_active, 0);
    wait_clk(1);
    check("to_rise", link_active, 1);
    wait_clk(TO - 1);
    check("to_last", link_active, 1);
    wait_clk(1);
    check("to_drop", link_active, 0);
    wait_clk(50);
    check("to_sat", link_active, 0);
    run_frame(16'($urandom), 16'($urandom), 24, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
- Responder (adapter) end of the DB15 serial joystick link.
- Presents two 12-bit button vectors to a DB15 reader as a 74HC165-style chain:
  - active-low parallel load on joy_load;
  - serial shift on the rising edge of joy_clk;
  - data out on joy_data.
- Used as a bench model for the reader.
- Used in multi-board setups where one MiSTer forwards its controls to another over the user port.

Parameters:
- BTN_BITS, 12: buttons per player, order FEDCBAUDLR.
- TIMEOUT_CYC, 2400000: clk cycles without a load pulse before link_active drops (about 50 ms at 48 MHz).

Ports:
- clk, input, 1: system clock, 40-50 MHz.
- reset_n, input, 1: asynchronous active-low reset.
- joystick1, input, 16: player 1 buttons, active high; [11:0] used, [15:12] ignored.
- joystick2, input, 16: player 2 buttons, active high; [11:0] used, [15:12] ignored.
- joy_clk, input, 1: shift clock from reader, asynchronous.
- joy_load, input, 1: parallel load from reader, active low, asynchronous.
- joy_data, output, 1: serial data to reader, active low (0 = pressed).
- frame_done, output, 1: one-clk pulse when the last frame bit has been shifted out.
- overrun, output, 1: sticky; set on a shift past the frame end, cleared on the next load.
- link_active, output, 1: high while load pulses arrive within TIMEOUT_CYC.

Behaviour:
- Clock and reset: one clock domain, clk. reset_n is asynchronous and active-low.
- Reset values:
  - joy_data=1, frame_done=0, overrun=0, link_active=0.
  - Shift register all 1s, bit_cnt=0, timeout counter=0.
- Input synchronisation:
  - joy_clk and joy_load each pass through a 2-FF synchronizer plus a previous-sample register.
  - Edge detect is on synchronized values. Input-to-action latency is 3 clk.
- Frame: FRAME=2*BTN_BITS=24 bits. Shift order is joystick1[0..11], then joystick2[0..11]. Wire value is the inverted button.
- State LOAD (sync joy_load==0):
  - Register loads ~{joystick2[11:0],joystick1[11:0]} every clk, so it is transparent to input changes.
  - bit_cnt=0, overrun=0.
  - joy_data = ~joystick1[0], registered with 1 clk latency.
  - joy_clk edges are ignored.
- Transition LOAD->SHIFT: on the sync rising edge of joy_load. The timeout counter clears and link_active=1 on the same edge.
- State SHIFT (sync joy_load==1), on each sync joy_clk rising edge:
  - Register shifts right with serial-in 1.
  - joy_data takes the new LSB on the following clk. Data is valid 4 clk after the physical rising edge of joy_clk.
  - bit_cnt increments and saturates at FRAME.
- Frame-end handling:
  - The shift that takes bit_cnt from FRAME-1 to FRAME pulses frame_done for exactly 1 clk. After this shift joy_data=1 (idle).
  - Any shift with bit_cnt==FRAME sets overrun; joy_data stays 1.
- Simultaneous sync load falling edge and clk rising edge: load wins and the shift is dropped.
- Reader timing requirement: joy_clk high and low phases are each at least 4 clk; joy_load low is at least 4 clk. Shorter pulses are undefined.
- Timeout counter:
  - 22-bit, increments each clk, saturates at TIMEOUT_CYC.
  - At TIMEOUT_CYC-1 -> TIMEOUT_CYC, link_active=0.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, no shifting until the next load pulse; joy_data stays 1.

Optional Feature:
- Macro: JOY_DB15_TX_GLITCH_FILTER_EN.
- When defined:
  - A 3-sample majority filter follows each synchronizer; latency becomes 5 clk and data is valid 6 clk after the physical edge.
  - Minimum phase widths become 6 clk.
  - Single-clk glitches on joy_clk/joy_load cause no shift or load.
- When undefined: plain 2-FF synchronizer and the timings above.

Decomposition:
- Package joy_db15_pkg:
  - localparams: BTN_BITS_DEF=12, FRAME_BITS_DEF=24, SYNC_LAT=3, SYNC_LAT_FILT=5.
  - typedef enum {ST_LOAD, ST_SHIFT} db15_tx_state_t.
  - typedef logic [11:0] db15_btn_t.
- Sub-module joy_db15_sync: synchronizer, optional majority filter, rise/fall pulses; instantiated for joy_clk and joy_load.
- Shift register, counters and status stay in joy_db15_tx.

Test Plan:
- Reset: reset_n=0 with joy_load toggling -> joy_data=1, link_active=0, overrun=0; no shifts after release until a load.
- Full frame: joystick1=16'h0015, joystick2=16'h0A00, load, 24 clocks -> serial bits
  - 0,1,0,1,0,1,1,1,1,1,1,1,
  - 1,1,1,1,1,1,1,1,1,0,1,0;
  - frame_done pulses once, after shift 24.
- Overrun: 26 clocks after one load -> bits 25 and 26 read 1, overrun=1 after shift 25; next load clears overrun.
- Load transparency: joystick1 changes 0->1 while joy_load low -> joy_data goes 1->0 within 2 clk; clocks during load cause no shift (bit_cnt=0).
- Timeout: TIMEOUT_CYC=1000, one load, then idle -> link_active=1 until cycle 1000 after the load edge, then 0; next load re-asserts it.
- With JOY_DB15_TX_GLITCH_FILTER_EN: 1-clk-wide joy_clk pulses -> no shift; 6-clk pulses shift correctly.
